// File: rtl/pio_svc_pkg.sv
// pio_svc_pkg: shared FSM states, PIO register map and event layout for pio_irq_servicer.
package pio_svc_pkg;

   typedef enum logic [2:0] {
      S_INIT_MASK, S_IDLE, S_RD_EDGE, S_WAIT_EDGE, S_WR_CLR, S_RD_DATA, S_WAIT_DATA, S_PUSH
   } pio_svc_state_e;

   localparam logic [2:0] ST_INIT_MASK = S_INIT_MASK;
   localparam logic [2:0] ST_IDLE      = S_IDLE;
   localparam logic [2:0] ST_RD_EDGE   = S_RD_EDGE;
   localparam logic [2:0] ST_WAIT_EDGE = S_WAIT_EDGE;
   localparam logic [2:0] ST_WR_CLR    = S_WR_CLR;
   localparam logic [2:0] ST_RD_DATA   = S_RD_DATA;
   localparam logic [2:0] ST_WAIT_DATA = S_WAIT_DATA;
   localparam logic [2:0] ST_PUSH      = S_PUSH;

   localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
   localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
   localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

   // Widest event the servicer can produce; instances store only the configured slice.
   typedef struct packed {
      logic [31:0] ts;
      logic [31:0] edges;
      logic [31:0] data;
   } pio_svc_event_t;

endpackage

// File: rtl/pio_svc_event_fifo.sv
// pio_svc_event_fifo: first-word-fall-through event FIFO with full/empty flags.
module pio_svc_event_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW:0]   wp, rp;

   assign empty = wp == rp;
   assign full  = (wp ^ rp) == {1'b1, {AW{1'b0}}};
   assign rdata = mem[rp[AW-1:0]];

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wp <= '0;
         rp <= '0;
      end else begin
         wp <= (push && !full) ? wp + 1'b1 : wp;
         rp <= (pop && !empty) ? rp + 1'b1 : rp;
      end

   always_ff @(posedge clk)
      if (push && !full) mem[wp[AW-1:0]] <= wdata;

endmodule

// File: rtl/pio_irq_servicer.sv
// pio_irq_servicer: Avalon-MM master that services the edge-capture PIO interrupt and streams events.
// Optional PIO_SVC_TIMESTAMP_EN adds a free-running cycle timestamp to every event.
module pio_irq_servicer
   import pio_svc_pkg::*;
#(
   parameter int          WIDTH         = 4,
   parameter logic [31:0] IRQ_MASK_INIT = 32'hF,
   parameter int          FIFO_DEPTH    = 4,
   parameter int          READ_LATENCY  = 1,
   parameter int          TS_WIDTH      = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable,
   input  logic                irq,
   output logic [1:0]          m_address,
   output logic                m_chipselect,
   output logic                m_write_n,
   output logic [31:0]         m_writedata,
   input  logic [31:0]         m_readdata,
   input  logic                m_waitrequest,
   output logic                ev_valid,
   input  logic                ev_ready,
   output logic [WIDTH-1:0]    ev_edges,
   output logic [WIDTH-1:0]    ev_data,
   output logic [TS_WIDTH-1:0] ev_ts,
   output logic                busy
);

`ifdef PIO_SVC_TIMESTAMP_EN
   localparam int EW = TS_WIDTH + 2 * WIDTH;
`else
   localparam int EW = 2 * WIDTH;
`endif

   logic [2:0]       state;
   logic             init_done;
   logic [1:0]       lat_cnt;
   logic [WIDTH-1:0] edges, data;
   logic             fifo_full, fifo_empty, start, rd_ready, unused_rd;
   logic [EW-1:0]    fifo_wdata, fifo_rdata;

   assign start     = init_done && irq && enable && !fifo_full;
   assign rd_ready  = lat_cnt == 2'(READ_LATENCY);
   assign busy      = state != ST_IDLE;
   assign unused_rd = ^m_readdata;

   // Reset parks in IDLE with init_done low so busy reads 0 until the mask write starts.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state        <= ST_IDLE;
         init_done    <= 1'b0;
         lat_cnt      <= '0;
         edges        <= '0;
         data         <= '0;
         m_chipselect <= 1'b0;
         m_write_n    <= 1'b1;
         m_address    <= '0;
         m_writedata  <= '0;
      end else begin
         case (state)
            ST_IDLE:
               if (!init_done) begin
                  state        <= ST_INIT_MASK;
                  m_chipselect <= 1'b1;
                  m_write_n    <= 1'b0;
                  m_address    <= PIO_ADDR_MASK;
                  m_writedata  <= IRQ_MASK_INIT;
               end else if (start) begin
                  state        <= ST_RD_EDGE;
                  m_chipselect <= 1'b1;
                  m_write_n    <= 1'b1;
                  m_address    <= PIO_ADDR_EDGE;
                  m_writedata  <= '0;
               end
            ST_INIT_MASK:
               if (!m_waitrequest) begin
                  state        <= ST_IDLE;
                  init_done    <= 1'b1;
                  m_chipselect <= 1'b0;
               end
            ST_RD_EDGE:
               if (!m_waitrequest) begin
                  state        <= ST_WAIT_EDGE;
                  m_chipselect <= 1'b0;
                  lat_cnt      <= 2'd1;
               end
            ST_WAIT_EDGE:
               if (rd_ready) begin
                  edges        <= m_readdata[WIDTH-1:0];
                  state        <= |m_readdata[WIDTH-1:0] ? ST_WR_CLR : ST_IDLE;
                  m_chipselect <= |m_readdata[WIDTH-1:0];
                  m_write_n    <= ~|m_readdata[WIDTH-1:0];
                  m_address    <= PIO_ADDR_EDGE;
                  m_writedata  <= '0;
               end else lat_cnt <= lat_cnt + 2'd1;
            ST_WR_CLR:
               if (!m_waitrequest) begin
                  state     <= ST_RD_DATA;
                  m_write_n <= 1'b1;
                  m_address <= PIO_ADDR_DATA;
               end
            ST_RD_DATA:
               if (!m_waitrequest) begin
                  state        <= ST_WAIT_DATA;
                  m_chipselect <= 1'b0;
                  lat_cnt      <= 2'd1;
               end
            ST_WAIT_DATA:
               if (rd_ready) begin
                  data  <= m_readdata[WIDTH-1:0];
                  state <= ST_PUSH;
               end else lat_cnt <= lat_cnt + 2'd1;
            default: state <= ST_IDLE;
         endcase
      end

`ifdef PIO_SVC_TIMESTAMP_EN
   logic [TS_WIDTH-1:0] ts_cnt, ts_lat;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         ts_cnt <= '0;
         ts_lat <= '0;
      end else begin
         ts_cnt <= ts_cnt + 1'b1;
         ts_lat <= (state == ST_IDLE && start) ? ts_cnt : ts_lat;
      end
   assign fifo_wdata = {ts_lat, edges, data};
   assign ev_ts      = fifo_rdata[EW-1 -: TS_WIDTH];
`else
   assign fifo_wdata = {edges, data};
   assign ev_ts      = '0;
`endif

   pio_svc_event_fifo #(.DW(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .reset_n(reset_n),
      .push   (state == ST_PUSH),
      .wdata  (fifo_wdata),
      .pop    (ev_valid && ev_ready),
      .rdata  (fifo_rdata),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign ev_valid = !fifo_empty;
   assign ev_edges = fifo_rdata[2*WIDTH-1:WIDTH];
   assign ev_data  = fifo_rdata[WIDTH-1:0];

endmodule

// File: doc/pio_irq_servicer.md
# pio_irq_servicer

Hardware interrupt servicer for the Nios II system's edge-capture input PIO. It acts as an Avalon-MM master on the PIO's s1 slave: it programs the interrupt mask, waits for `irq`, reads and clears the edge-capture register, samples the data register, and delivers each service as an event word on a valid/ready stream. This offloads PIO interrupt handling from the CPU for the I2C master control path.

## Interface
- `WIDTH`, 4, PIO input width (bits of edge/data used).
- `IRQ_MASK_INIT`, 4'hF, value written to the PIO irq mask after reset.
- `FIFO_DEPTH`, 4, event FIFO depth in entries; power of two, 2..16.
- `READ_LATENCY`, 1, slave read latency in cycles after the accepted read (1..3).
- `TS_WIDTH`, 16, timestamp width; used only with `PIO_SVC_TIMESTAMP_EN`.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when low, no new service starts; an in-flight service completes.
- `irq`  in  1  PIO interrupt, level.
- `m_address`  out  2  PIO register address.
- `m_chipselect`  out  1  transfer request.
- `m_write_n`  out  1  0 = write, 1 = read.
- `m_writedata`  out  32  write data.
- `m_readdata`  in  32  read data.
- `m_waitrequest`  in  1  slave stall; tie 0 for the PIO.
- `ev_valid`  out  1  event available at FIFO head.
- `ev_ready`  in  1  consumer accepts head.
- `ev_edges`  out  WIDTH  captured edge bits.
- `ev_data`  out  WIDTH  data register value sampled after the clear.
- `ev_ts`  out  TS_WIDTH  cycle timestamp of irq sample (macro only).
- `busy`  out  1  FSM not in IDLE.

## Operation
- Register map (slave): 0 = data, 2 = irq mask, 3 = edge capture. A write to address 3 clears all capture bits.
- FSM: INIT_MASK → IDLE → RD_EDGE → WAIT_EDGE → WR_CLR → RD_DATA → WAIT_DATA → PUSH → IDLE.
- INIT_MASK: write `IRQ_MASK_INIT` to address 2, then go to IDLE.
- IDLE: when `irq && enable && !fifo_full`, latch the timestamp and go to RD_EDGE. While the FIFO is full, edges stay accumulated in the slave; none are dropped here.
- RD_EDGE: issue a read at address 3. WAIT_EDGE: capture `m_readdata[WIDTH-1:0]` exactly `READ_LATENCY` cycles after acceptance.
- Captured edges == 0 (spurious): return to IDLE with no clear and no push.
- WR_CLR: write 0 to address 3. RD_DATA/WAIT_DATA: read address 0 and capture data the same way.
- PUSH: write {ts, edges, data} into the FIFO; the FIFO cannot be full at this point.
- Known limitation: an edge arriving between the edge-capture read and its clear write is lost. This is inherent to the slave.
- FIFO: first-word-fall-through. `ev_valid` = !empty; the head pops on `ev_valid && ev_ready`. A push and a pop in the same cycle while full is not possible, because IDLE blocks when full.

## Timing
- Reset values: `m_chipselect` 0, `m_write_n` 1, `m_address` 0, `m_writedata` 0, `ev_valid` 0, `busy` 0, FIFO empty, timestamp 0.
- INIT_MASK starts on the first clock after reset release.
- Transfer: `m_address`, `m_write_n` and `m_writedata` are registered outputs, stable while `m_chipselect`=1. A transfer is accepted in the first cycle with `m_waitrequest`=0, and `m_chipselect` drops the next cycle. Each transfer is one cycle minimum.
- With `m_waitrequest`=0 and `READ_LATENCY`=1: irq sampled in IDLE at cycle n gives RD_EDGE n+1, edges captured n+2, WR_CLR n+3, RD_DATA n+4, data captured n+5, PUSH n+6, `ev_valid` high n+7.
- `irq` falls one cycle after the clear write. The FSM does not resample `irq` before PUSH.
- Reset asserted mid-service aborts all transfers combinationally-safe (registered outputs to reset values), empties the FIFO, and restarts at INIT_MASK.
- `enable` falling mid-service: the service completes and the FSM waits in IDLE.

## Configuration
- `PIO_SVC_TIMESTAMP_EN` defined: a free-running `TS_WIDTH` counter (wraps modulo 2^TS_WIDTH) is latched at the irq sample and stored per event; `ev_ts` is valid.
- Undefined: no counter and no FIFO timestamp field; `ev_ts` is driven 0.

## Structure
- Package `pio_svc_pkg`: FSM state enum, register address constants (`PIO_ADDR_DATA`=0, `PIO_ADDR_MASK`=2, `PIO_ADDR_EDGE`=3), event struct typedef.
- Sub-module `pio_svc_event_fifo`: synchronous FWFT FIFO, depth `FIFO_DEPTH`, with full/empty flags.

## Test plan
- Reset release → first transfer is a write of 0xF to address 2; `busy` returns to 0 after it.
- Falling edge on `in_port[2]` with data then 4'b1011 → one event edges=4'b0100, data=4'b1011; `ev_valid` 7 cycles after `irq` rises; `irq` low after clear.
- `ev_ready`=0 and 5 separate edges with `FIFO_DEPTH`=4 → 4 events queued; the 5th edge is held in the slave and serviced after one pop; no loss.
- `m_waitrequest` held high 3 cycles on each transfer → outputs stable throughout; event identical to zero-wait case, 9 cycles later.
- Forced `irq` with edge register 0 → one read, no write, no event.
- Reset asserted during WAIT_DATA → outputs at reset values; restart with mask write; FIFO empty.
